// File: rtl/serv_fetch_pkg.sv
// Shared types for the instruction fetch aligner: FSM states and compressed-instruction detection.
package serv_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH0,
        FETCH1,
        RESP
    } fetch_state_e;

    // Low two bits of a 32-bit (uncompressed) RISC-V opcode.
    localparam logic [1:0] RVC_UNCOMP = 2'b11;

    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != RVC_UNCOMP;
    endfunction

endpackage

// File: rtl/serv_fetch_wordbuf.sv
// Single-entry word buffer: holds the last fetched memory word with its word-address tag.
// Latency: hit is combinational on rd_tag; writes and flushes take effect on the next edge.
// Backpressure: none; flush beats a simultaneous write so the entry stays invalid.
module serv_fetch_wordbuf
    import serv_fetch_pkg::*;
#(
    parameter int AW       = 32,
    parameter int CACHE_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [AW-3:0] wr_tag,
    input  logic [31:0]   wr_dat,
    input  logic [AW-3:0] rd_tag,
    output logic          hit,
    output logic [31:0]   rd_dat
);

    logic          valid_q, valid_d;
    logic [AW-3:0] tag_q,   tag_d;
    logic [31:0]   data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d = 1'b1;
            tag_d   = wr_tag;
            data_d  = wr_dat;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit    = (CACHE_EN != 0) && valid_q && (tag_q == rd_tag);
    assign rd_dat = data_q;

endmodule

// File: rtl/serv_fetch_aligner.sv
// Turns halfword-aligned CPU fetches into word-aligned memory reads, splitting straddling instructions.
// Latency (zero-wait memory): hit 1 cycle, aligned miss 2, misaligned uncompressed miss 3.
// Backpressure: waits in FETCH0/FETCH1 for i_wb_ibus_ack; dropping i_ibus_cyc aborts without an ack.
module serv_fetch_aligner
    import serv_fetch_pkg::*;
#(
    parameter int AW       = 32,
    parameter int C_EXT    = 1,
    parameter int CACHE_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_ibus_adr,
    input  logic          i_ibus_cyc,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic          i_flush,
    output logic [AW-1:0] o_wb_ibus_adr,
    output logic          o_wb_ibus_cyc,
    input  logic [31:0]   i_wb_ibus_rdt,
    input  logic          i_wb_ibus_ack
);

    fetch_state_e state_q, state_d;
    logic [31:0]  rdt_q,   rdt_d;
    logic [15:0]  hi_hw_q, hi_hw_d;

    logic [AW-1:0] w_adr;
    logic [AW-1:0] w_adr_nxt;
    logic          misal;
    logic          unused_adr0;

    logic          buf_hit;
    logic [31:0]   buf_dat;
    logic          buf_wr_en;
    logic [AW-3:0] buf_wr_tag;

    assign w_adr       = {i_ibus_adr[AW-1:2], 2'b00};
    assign w_adr_nxt   = w_adr + {{(AW-3){1'b0}}, 3'b100};
    assign misal       = i_ibus_adr[1];
    assign unused_adr0 = i_ibus_adr[0];

    serv_fetch_wordbuf #(
        .AW       (AW),
        .CACHE_EN (CACHE_EN)
    ) u_wordbuf (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (i_flush),
        .wr_en  (buf_wr_en),
        .wr_tag (buf_wr_tag),
        .wr_dat (i_wb_ibus_rdt),
        .rd_tag (w_adr[AW-1:2]),
        .hit    (buf_hit),
        .rd_dat (buf_dat)
    );

    always_comb begin
        state_d       = state_q;
        rdt_d         = rdt_q;
        hi_hw_d       = hi_hw_q;
        buf_wr_en     = 1'b0;
        buf_wr_tag    = w_adr[AW-1:2];
        o_wb_ibus_cyc = 1'b0;
        o_wb_ibus_adr = w_adr;

        case (state_q)
            IDLE: begin
                if (i_ibus_cyc) begin
                    if (!buf_hit) begin
                        state_d = FETCH0;
                    end else if (!misal) begin
                        rdt_d   = buf_dat;
                        state_d = RESP;
                    end else begin
                        hi_hw_d = buf_dat[31:16];
                        if ((C_EXT != 0) && is_compressed(buf_dat[31:16])) begin
                            rdt_d   = {16'h0000, buf_dat[31:16]};
                            state_d = RESP;
                        end else begin
                            state_d = FETCH1;
                        end
                    end
                end
            end

            FETCH0: begin
                if (!i_ibus_cyc) begin
                    state_d = IDLE;
                end else begin
                    o_wb_ibus_cyc = 1'b1;
                    if (i_wb_ibus_ack) begin
                        buf_wr_en = 1'b1;
                        hi_hw_d   = i_wb_ibus_rdt[31:16];
                        if (!misal) begin
                            rdt_d   = i_wb_ibus_rdt;
                            state_d = RESP;
                        end else if ((C_EXT != 0) && is_compressed(i_wb_ibus_rdt[31:16])) begin
                            rdt_d   = {16'h0000, i_wb_ibus_rdt[31:16]};
                            state_d = RESP;
                        end else begin
                            state_d = FETCH1;
                        end
                    end
                end
            end

            FETCH1: begin
                if (!i_ibus_cyc) begin
                    state_d = IDLE;
                end else begin
                    o_wb_ibus_cyc = 1'b1;
                    o_wb_ibus_adr = w_adr_nxt;
                    buf_wr_tag    = w_adr_nxt[AW-1:2];
                    if (i_wb_ibus_ack) begin
                        buf_wr_en = 1'b1;
                        rdt_d     = {i_wb_ibus_rdt[15:0], hi_hw_q};
                        state_d   = RESP;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdt_q   <= '0;
            hi_hw_q <= '0;
        end else begin
            state_q <= state_d;
            rdt_q   <= rdt_d;
            hi_hw_q <= hi_hw_d;
        end
    end

    assign o_ibus_ack = (state_q == RESP);
    assign o_ibus_rdt = rdt_q;

endmodule

// File: tb/tb_serv_fetch_aligner.sv
// Randomized bench for serv_fetch_aligner against a transaction-level fetch/cache model.
module tb_serv_fetch_aligner;

    localparam int AW       = 32;
    localparam int C_EXT    = 1;
    localparam int CACHE_EN = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] i_ibus_adr;
    logic          i_ibus_cyc;
    logic [31:0]   o_ibus_rdt;
    logic          o_ibus_ack;
    logic          i_flush;
    logic [AW-1:0] o_wb_ibus_adr;
    logic          o_wb_ibus_cyc;
    logic [31:0]   i_wb_ibus_rdt;
    logic          i_wb_ibus_ack;

    serv_fetch_aligner #(
        .AW       (AW),
        .C_EXT    (C_EXT),
        .CACHE_EN (CACHE_EN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ibus_adr    (i_ibus_adr),
        .i_ibus_cyc    (i_ibus_cyc),
        .o_ibus_rdt    (o_ibus_rdt),
        .o_ibus_ack    (o_ibus_ack),
        .i_flush       (i_flush),
        .o_wb_ibus_adr (o_wb_ibus_adr),
        .o_wb_ibus_cyc (o_wb_ibus_cyc),
        .i_wb_ibus_rdt (i_wb_ibus_rdt),
        .i_wb_ibus_ack (i_wb_ibus_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory image: a hash of the word address, with a few words pinned for directed cases.
    logic [31:0] ov_adr [8];
    logic [31:0] ov_dat [8];
    int          ov_n = 0;

    // Reference cache: what the last completed bus read left behind.
    bit          m_valid;
    logic [31:0] m_tag;
    logic [31:0] m_word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        for (int i = 0; i < ov_n; i++) begin
            if (ov_adr[i] == w) return ov_dat[i];
        end
        return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F ^ {w[15:0], w[31:16]};
    endfunction

    task automatic set_mem(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < ov_n; i++) begin
            if (ov_adr[i] == a) begin
                ov_dat[i] = d;
                return;
            end
        end
        ov_adr[ov_n] = a;
        ov_dat[ov_n] = d;
        ov_n++;
    endtask

    task automatic predict(input logic [31:0] adr, output logic [31:0] e_rdt,
                           output logic [31:0] f0, output logic [31:0] f1, output int n);
        logic [31:0] w, w4, lo, nxt;
        logic [15:0] hi;
        bit          hit, comp;
        w    = {adr[31:2], 2'b00};
        w4   = w + 32'd4;
        hit  = (CACHE_EN != 0) && m_valid && (m_tag == w);
        lo   = hit ? m_word : mem_rd(w);
        hi   = lo[31:16];
        comp = (C_EXT != 0) && (hi[1:0] != 2'b11);
        nxt  = mem_rd(w4);
        f0   = w;
        f1   = w4;
        if (!adr[1]) begin
            e_rdt = lo;
            n     = hit ? 0 : 1;
        end else begin
            e_rdt = comp ? {16'h0000, hi} : {nxt[15:0], hi};
            if (hit) begin
                n  = comp ? 0 : 1;
                f0 = w4;
            end else begin
                n = comp ? 1 : 2;
            end
        end
    endtask

    // Entered and left at a falling edge. abort_at >= 1 drops i_ibus_cyc in that cycle.
    task automatic do_req(input logic [31:0] adr, input int abort_at, input bit zw, input bit fl,
                          output logic [31:0] o_rdt, output int o_lat, output int o_nf,
                          output logic [31:0] o_f0, output logic [31:0] o_f1);
        logic [31:0] e_rdt, e_f0, e_f1, last;
        int          e_n, lat, waits;
        bit          done, aborted;
        logic [31:0] got_f [$];
        predict(adr, e_rdt, e_f0, e_f1, e_n);
        i_ibus_cyc = 1'b1;
        i_ibus_adr = adr;
        i_flush    = fl;
        lat = 0; waits = 0; done = 0; aborted = 0;
        o_rdt = '0;
        while (!done) begin
            if (abort_at == lat) i_ibus_cyc = 1'b0;
            #1;
            if (abort_at == lat) i_wb_ibus_ack = 1'b1;
            else i_wb_ibus_ack = o_wb_ibus_cyc && (zw || ($urandom_range(0, 2) != 0));
            i_wb_ibus_rdt = mem_rd(o_wb_ibus_adr);
            if (o_wb_ibus_cyc) begin
                if (o_wb_ibus_adr[1:0] != 2'b00) chk("wb_adr_align", o_wb_ibus_adr, {o_wb_ibus_adr[31:2], 2'b00});
                if (i_wb_ibus_ack) got_f.push_back(o_wb_ibus_adr);
                else waits++;
            end
            @(posedge clk);
            #1;
            lat++;
            if (abort_at == lat - 1) begin
                aborted = 1;
                done    = 1;
                chk("abort_no_ack", {31'd0, o_ibus_ack}, 32'd0);
            end else if (o_ibus_ack) begin
                done  = 1;
                o_rdt = o_ibus_rdt;
            end else if (lat > 200) begin
                chk("ack_timeout", 32'd1, 32'd0);
                done = 1;
            end
            @(negedge clk);
        end
        i_wb_ibus_ack = 1'b0;
        o_lat = lat;
        o_nf  = got_f.size();
        o_f0  = (got_f.size() > 0) ? got_f[0] : 32'd0;
        o_f1  = (got_f.size() > 1) ? got_f[1] : 32'd0;
        for (int i = 0; i < got_f.size() && i < 2; i++) begin
            chk("fetch_adr", got_f[i], (i == 0) ? e_f0 : e_f1);
        end
        if (aborted) begin
            chk("abort_fetch_le", {31'd0, (got_f.size() <= e_n)}, 32'd1);
            i_flush = 1'b0;
            @(posedge clk);
            #1;
            chk("abort_idle_ack", {31'd0, o_ibus_ack}, 32'd0);
            @(negedge clk);
        end else begin
            chk("rdt", o_rdt, e_rdt);
            chk("fetch_cnt", got_f.size(), e_n);
            chk("latency", lat, 1 + e_n + waits);
            i_ibus_cyc = 1'b0;
            i_flush    = 1'b0;
            @(posedge clk);
            #1;
            chk("ack_one_cycle", {31'd0, o_ibus_ack}, 32'd0);
            chk("rdt_hold", o_ibus_rdt, e_rdt);
            @(negedge clk);
        end
        if (fl) begin
            m_valid = 0;
        end else if (got_f.size() > 0) begin
            last    = got_f[got_f.size() - 1];
            m_valid = 1;
            m_tag   = last;
            m_word  = mem_rd(last);
        end
    endtask

    task automatic idle(input int n, input bit fl);
        i_flush = fl;
        for (int i = 0; i < n; i++) begin
            #1;
            if (o_wb_ibus_cyc || o_ibus_ack) chk("idle_quiet", {30'd0, o_wb_ibus_cyc, o_ibus_ack}, 32'd0);
            @(negedge clk);
            i_flush = 1'b0;
        end
        if (fl && n > 0) m_valid = 0;
    endtask

    initial begin
        logic [31:0] rdt, f0, f1, adr;
        int          lat, nf, ab;
        i_ibus_cyc    = 1'b0;
        i_ibus_adr    = '0;
        i_flush       = 1'b0;
        i_wb_ibus_ack = 1'b0;
        i_wb_ibus_rdt = '0;
        m_valid       = 0;
        m_tag         = '0;
        m_word        = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'd0, o_ibus_ack}, 32'd0);
        chk("rst_wb_cyc", {31'd0, o_wb_ibus_cyc}, 32'd0);
        chk("rst_rdt", o_ibus_rdt, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        set_mem(32'h100, 32'h00A00093);
        do_req(32'h100, -1, 1, 0, rdt, lat, nf, f0, f1);
        chk("al_miss_rdt", rdt, 32'h00A00093);
        chk("al_miss_lat", lat, 2);
        chk("al_miss_adr", f0, 32'h100);

        set_mem(32'h100, 32'h12375678);
        set_mem(32'h104, 32'h9ABCDEF3);
        idle(1, 1);
        do_req(32'h102, -1, 1, 0, rdt, lat, nf, f0, f1);
        chk("split_rdt", rdt, 32'hDEF31237);
        chk("split_lat", lat, 3);
        chk("split_adr0", f0, 32'h100);
        chk("split_adr1", f1, 32'h104);

        do_req(32'h104, -1, 1, 0, rdt, lat, nf, f0, f1);
        chk("hit_rdt", rdt, 32'h9ABCDEF3);
        chk("hit_lat", lat, 1);
        chk("hit_nf", nf, 0);

        do_req(32'h106, -1, 1, 0, rdt, lat, nf, f0, f1);
        chk("hit_rvc_rdt", rdt, 32'h00009ABC);
        chk("hit_rvc_nf", nf, 0);

        idle(1, 1);
        do_req(32'h104, -1, 1, 0, rdt, lat, nf, f0, f1);
        chk("flush_refetch_nf", nf, 1);
        chk("flush_refetch_adr", f0, 32'h104);

        set_mem(32'h200, 32'h4501BEEF);
        do_req(32'h202, -1, 1, 0, rdt, lat, nf, f0, f1);
        chk("rvc_rdt", rdt, 32'h00004501);
        chk("rvc_nf", nf, 1);
        chk("rvc_adr", f0, 32'h200);

        do_req(32'h400, 1, 1, 0, rdt, lat, nf, f0, f1);
        chk("abort_nf", nf, 0);
        do_req(32'h202, -1, 1, 0, rdt, lat, nf, f0, f1);
        chk("abort_keeps_valid_nf", nf, 0);
        chk("abort_keeps_valid_rdt", rdt, 32'h00004501);

        set_mem(32'hFFFFFFFC, 32'hABCF0000);
        set_mem(32'h00000000, 32'h11112222);
        do_req(32'hFFFFFFFE, -1, 1, 0, rdt, lat, nf, f0, f1);
        chk("wrap_adr0", f0, 32'hFFFFFFFC);
        chk("wrap_adr1", f1, 32'h00000000);
        chk("wrap_rdt", rdt, 32'h2222ABCF);

        do_req(32'h500, -1, 1, 1, rdt, lat, nf, f0, f1);
        do_req(32'h500, -1, 1, 0, rdt, lat, nf, f0, f1);
        chk("flush_beats_write_nf", nf, 1);

        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 9) == 0) adr = 32'hFFFFFFF8 + 2 * $urandom_range(0, 3);
            else adr = 32'h1000 + 2 * $urandom_range(0, 23);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : -1;
            do_req(adr, ab, $urandom_range(0, 1), ($urandom_range(0, 19) == 0), rdt, lat, nf, f0, f1);
            idle($urandom_range(0, 2), ($urandom_range(0, 9) == 0));
        end

        idle(1, 1);
        i_ibus_cyc = 1'b1;
        i_ibus_adr = 32'h700;
        @(posedge clk);
        #1;
        chk("mid_fetch_wb_cyc", {31'd0, o_wb_ibus_cyc}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wb_cyc", {31'd0, o_wb_ibus_cyc}, 32'd0);
        chk("mid_rst_ack", {31'd0, o_ibus_ack}, 32'd0);
        chk("mid_rst_rdt", o_ibus_rdt, 32'd0);
        @(negedge clk);
        i_ibus_cyc = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_valid = 0;
        @(negedge clk);
        do_req(32'h104, -1, 1, 0, rdt, lat, nf, f0, f1);
        chk("post_rst_refetch_nf", nf, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
